// File: rtl/uart_tx.sv
// -----------------------------------------------------------------------------
// uart_tx
//
// Serial transmitter for the UART link. Accepts a parallel word through a
// ready/start handshake and serialises it as: start bit (0), data LSB first,
// optional even-parity bit, stop bit (1). Every bit is held for CLKS_PER_BIT
// system clocks.
//
// Parameters
//   CLKS_PER_BIT  system clocks per serial bit (2..65535)
//   DATA_WIDTH    data bits per frame (5..9)
//   PARITY_EN     1 inserts an even-parity bit after the last data bit
//
// Ports
//   clk         in   system clock, rising edge
//   n_rst       in   asynchronous active-low reset
//   tx_data     in   word to send, sampled only on an accepted start
//   tx_start    in   send request, accepted when tx_ready=1 at a rising edge
//   tx_ready    out  idle, able to accept tx_start
//   tx_busy     out  frame in progress (inverse of tx_ready)
//   tx_done     out  one-cycle pulse after the stop bit completes
//   serial_out  out  registered serial line, idles high
// -----------------------------------------------------------------------------
module uart_tx #(
   parameter int CLKS_PER_BIT = 10,
   parameter int DATA_WIDTH   = 8,
   parameter bit PARITY_EN    = 1'b0
) (
   input  logic                  clk,
   input  logic                  n_rst,
   input  logic [DATA_WIDTH-1:0] tx_data,
   input  logic                  tx_start,
   output logic                  tx_ready,
   output logic                  tx_busy,
   output logic                  tx_done,
   output logic                  serial_out
);

   localparam int TIMER_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
   localparam int CNT_W   = $clog2(DATA_WIDTH + 1);

   localparam logic [TIMER_W-1:0] TIMER_LAST = TIMER_W'(CLKS_PER_BIT - 1);
   localparam logic [CNT_W-1:0]   CNT_LAST   = CNT_W'(DATA_WIDTH - 1);

   localparam logic [2:0] IDLE   = 3'd0;
   localparam logic [2:0] START  = 3'd1;
   localparam logic [2:0] DATA   = 3'd2;
   localparam logic [2:0] PARITY = 3'd3;
   localparam logic [2:0] STOP   = 3'd4;

   logic [2:0]            state;
   logic [DATA_WIDTH-1:0] shift_reg;
   logic [TIMER_W-1:0]    bit_timer;
   logic [CNT_W-1:0]      bit_cnt;
   logic                  parity_acc;   // running XOR of data bits already sent
   logic                  bit_expired;

   assign bit_expired = (bit_timer == TIMER_LAST);

   // Handshake flags decode the state register only, so no input reaches an
   // output combinationally.
   assign tx_ready = (state == IDLE);
   assign tx_busy  = ~tx_ready;

   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         state      <= IDLE;
         shift_reg  <= '0;
         bit_timer  <= '0;
         bit_cnt    <= '0;
         parity_acc <= 1'b0;
         serial_out <= 1'b1;
         tx_done    <= 1'b0;
      end else begin
         // NOTE: non-blocking assignments throughout, so every branch below
         // reads the pre-edge value of shift_reg/parity_acc/bit_cnt.
         tx_done <= 1'b0;

         case (state)
            IDLE: begin
               serial_out <= 1'b1;
               bit_timer  <= '0;
               if (tx_start) begin
                  shift_reg  <= tx_data;
                  bit_cnt    <= '0;
                  parity_acc <= 1'b0;
                  serial_out <= 1'b0;
                  state      <= START;
               end
            end

            START: begin
               if (bit_expired) begin
                  bit_timer  <= '0;
                  serial_out <= shift_reg[0];
                  state      <= DATA;
               end else begin
                  bit_timer <= bit_timer + TIMER_W'(1);
               end
            end

            DATA: begin
               if (bit_expired) begin
                  bit_timer  <= '0;
                  shift_reg  <= {1'b0, shift_reg[DATA_WIDTH-1:1]};
                  parity_acc <= parity_acc ^ shift_reg[0];
                  bit_cnt    <= bit_cnt + CNT_W'(1);
                  if (bit_cnt == CNT_LAST) begin
                     if (PARITY_EN) begin
                        // Fold in the last data bit, which is still in shift_reg[0].
                        serial_out <= parity_acc ^ shift_reg[0];
                        state      <= PARITY;
                     end else begin
                        serial_out <= 1'b1;
                        state      <= STOP;
                     end
                  end else begin
                     // shift_reg has not moved yet, so the next bit sits at [1].
                     serial_out <= shift_reg[1];
                  end
               end else begin
                  bit_timer <= bit_timer + TIMER_W'(1);
               end
            end

            PARITY: begin
               if (bit_expired) begin
                  bit_timer  <= '0;
                  serial_out <= 1'b1;
                  state      <= STOP;
               end else begin
                  bit_timer <= bit_timer + TIMER_W'(1);
               end
            end

            STOP: begin
               if (bit_expired) begin
                  bit_timer <= '0;
                  tx_done   <= 1'b1;
                  state     <= IDLE;
               end else begin
                  bit_timer <= bit_timer + TIMER_W'(1);
               end
            end

            default: begin
               bit_timer  <= '0;
               serial_out <= 1'b1;
               state      <= IDLE;
            end
         endcase
      end
   end

endmodule
